// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter.
// Requester IDs double as bit positions in the grant vector and as the
// read-owner encoding.
package mem_port_arbiter_pkg;

    // Requester identifiers (grant vector index / read-owner value)
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam int NUM_REQ = 2;

    // Default number of denied fetch cycles before fetch is forced through
    localparam int DEFAULT_STARVE_LIMIT = 4;

    // Width of the starvation counter; limits above 255 cannot be expressed
    localparam int STARVE_CNT_W = 8;

    // Saturating increment used by the starvation counter
    function automatic logic [STARVE_CNT_W-1:0] starve_sat_inc(
        input logic [STARVE_CNT_W-1:0] cnt,
        input logic [STARVE_CNT_W-1:0] limit
    );
        if (cnt >= limit) begin
            return limit;
        end
        return cnt + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Priority grant for the shared memory port: data wins by default, but a
// fetch request denied STARVE_LIMIT cycles in a row is forced through.
// The grant is purely combinational on the request inputs so the port mux
// can issue the access in the same cycle as the request.
module mem_arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_if_req,
    input  logic                i_d_req,
    output logic [NUM_REQ-1:0]  o_gnt
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_reg;
    logic [STARVE_CNT_W-1:0] starve_cnt_next;
    logic                    starve_hit;
    logic                    gnt_if;
    logic                    gnt_d;

    assign starve_hit = (starve_cnt_reg == LIMIT);

    // Fixed data priority, overridden once fetch has waited long enough
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (i_if_req && i_d_req) begin
            gnt_if = starve_hit;
            gnt_d  = !starve_hit;
        end else if (i_d_req) begin
            gnt_d  = 1'b1;
        end else if (i_if_req) begin
            gnt_if = 1'b1;
        end
    end

    always_comb begin
        o_gnt         = '0;
        o_gnt[REQ_IF] = gnt_if;
        o_gnt[REQ_D]  = gnt_d;
    end

    // Count consecutive cycles in which a pending fetch was denied
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!i_if_req || gnt_if) begin
            starve_cnt_next = '0;
        end else begin
            starve_cnt_next = starve_sat_inc(starve_cnt_reg, LIMIT);
        end
    end

    // Starvation counter register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and
// the MEM-stage data requester. At most one access is issued per cycle; read
// data returns one cycle after the grant and is steered to whoever issued it.
// Optional build macro MEM_ARB_STATS_EN adds conflict and starvation-win
// counters as extra outputs.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 8,
    parameter int W            = 32,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [W-1:0]  o_if_rdata,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [W-1:0]  i_d_wdata,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    output logic [W-1:0]  o_d_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic [W-1:0]  o_mem_wdata,
    output logic          o_mem_read,
    output logic          o_mem_write,
    input  logic [W-1:0]  i_mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]   o_conflict_cnt,
    output logic [15:0]   o_starve_wins
`endif
);

    logic [NUM_REQ-1:0] gnt;
    logic               gnt_if;
    logic               gnt_d;
    logic               rd_grant;

    logic               rd_pending_reg;
    logic               rd_pending_next;
    logic               rd_owner_reg;
    logic               rd_owner_next;

    logic [NUM_REQ-1:0] rvalid_vec;
    logic [W-1:0]       rdata_vec [NUM_REQ];

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_if_req (i_if_req),
        .i_d_req  (i_d_req),
        .o_gnt    (gnt)
    );

    assign gnt_if   = gnt[REQ_IF];
    assign gnt_d    = gnt[REQ_D];
    assign o_if_gnt = gnt_if;
    assign o_d_gnt  = gnt_d;

    // Any read issued this cycle, regardless of requester
    assign rd_grant = gnt_if | (gnt_d & ~i_d_we);

    // Memory port mux: steer the granted requester onto the memory; idle is all-zero
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (gnt_d) begin
            o_mem_addr  = i_d_addr;
            o_mem_wdata = i_d_wdata;
        end else if (gnt_if) begin
            o_mem_addr  = i_if_addr;
        end
    end

    // Memory enables; held off during reset so no access is issued into a
    // pipeline that is being flushed
    always_comb begin
        o_mem_read  = rd_grant & ~i_reset;
        o_mem_write = gnt_d & i_d_we & ~i_reset;
    end

    // Remember which requester owns the read data arriving next cycle
    always_comb begin
        rd_pending_next = rd_grant;
        rd_owner_next   = rd_owner_reg;
        if (rd_grant) begin
            rd_owner_next = gnt_d ? REQ_D : REQ_IF;
        end
    end

    // Read-ownership registers; reset discards any outstanding read
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_pending_reg <= 1'b0;
            rd_owner_reg   <= REQ_IF;
        end else begin
            rd_pending_reg <= rd_pending_next;
            rd_owner_reg   <= rd_owner_next;
        end
    end

    // Per-requester response steering; the non-owner sees zero data
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
            assign rvalid_vec[gi] = rd_pending_reg & (rd_owner_reg == 1'(gi));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? i_mem_rdata : '0;
        end
    endgenerate

    assign o_if_rvalid = rvalid_vec[REQ_IF];
    assign o_if_rdata  = rdata_vec[REQ_IF];
    assign o_d_rvalid  = rvalid_vec[REQ_D];
    assign o_d_rdata   = rdata_vec[REQ_D];

`ifdef MEM_ARB_STATS_EN
    logic [31:0] conflict_cnt_reg;
    logic [31:0] conflict_cnt_next;
    logic [15:0] starve_wins_reg;
    logic [15:0] starve_wins_next;
    logic        starve_win;

    // Fetch can only beat a concurrent data request through the starvation rule
    assign starve_win = gnt_if & i_d_req;

    // Conflict counter wraps; starvation-win counter saturates
    always_comb begin
        conflict_cnt_next = conflict_cnt_reg;
        starve_wins_next  = starve_wins_reg;
        if (i_if_req && i_d_req) begin
            conflict_cnt_next = conflict_cnt_reg + 32'd1;
        end
        if (starve_win && (starve_wins_reg != 16'hFFFF)) begin
            starve_wins_next = starve_wins_reg + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            conflict_cnt_reg <= '0;
            starve_wins_reg  <= '0;
        end else begin
            conflict_cnt_reg <= conflict_cnt_next;
            starve_wins_reg  <= starve_wins_next;
        end
    end

    assign o_conflict_cnt = conflict_cnt_reg;
    assign o_starve_wins  = starve_wins_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256-word memory
// (registered read). Memory word at address a is preloaded to 0xA0000000|a.
module tb_mem_port_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic        i_if_req;
    logic [7:0]  i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_d_req;
    logic        i_d_we;
    logic [7:0]  i_d_addr;
    logic [31:0] i_d_wdata;
    logic        o_d_gnt;
    logic        o_d_rvalid;
    logic [31:0] o_d_rdata;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [31:0] i_mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] o_conflict_cnt;
    logic [15:0] o_starve_wins;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [256];
    logic [31:0] exp_fetch [3];
    logic        exp_f;

    mem_port_arbiter #(
        .AW (8),
        .W  (32),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_gnt    (o_if_gnt),
        .o_if_rvalid (o_if_rvalid),
        .o_if_rdata  (o_if_rdata),
        .i_d_req     (i_d_req),
        .i_d_we      (i_d_we),
        .i_d_addr    (i_d_addr),
        .i_d_wdata   (i_d_wdata),
        .o_d_gnt     (o_d_gnt),
        .o_d_rvalid  (o_d_rvalid),
        .o_d_rdata   (o_d_rdata),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_read  (o_mem_read),
        .o_mem_write (o_mem_write),
        .i_mem_rdata (i_mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .o_conflict_cnt (o_conflict_cnt),
        .o_starve_wins  (o_starve_wins)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural single-port memory, reloaded with its pattern during reset
    always @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 32'hA000_0000 | 32'(i);
            end
            i_mem_rdata <= '0;
        end else begin
            if (o_mem_write) begin
                mem[o_mem_addr] <= o_mem_wdata;
            end
            if (o_mem_read) begin
                i_mem_rdata <= mem[o_mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic if_req, input logic [7:0] if_addr,
                         input logic d_req, input logic d_we,
                         input logic [7:0] d_addr, input logic [31:0] d_wdata);
        i_if_req  = if_req;
        i_if_addr = if_addr;
        i_d_req   = d_req;
        i_d_we    = d_we;
        i_d_addr  = d_addr;
        i_d_wdata = d_wdata;
    endtask

    initial begin
        exp_fetch[0] = 32'hA000_0000;
        exp_fetch[1] = 32'hA000_0004;
        exp_fetch[2] = 32'hA000_0008;

        i_reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (2) @(posedge i_clk);
        #1;
        $display("txn reset: checking idle outputs");
        chk("rst_if_rvalid", 32'(o_if_rvalid), 32'd0);
        chk("rst_d_rvalid",  32'(o_d_rvalid),  32'd0);
        chk("rst_mem_read",  32'(o_mem_read),  32'd0);
        chk("rst_mem_write", 32'(o_mem_write), 32'd0);
        chk("rst_if_rdata",  o_if_rdata,       32'd0);

        @(negedge i_clk);
        i_reset = 1'b0;

        // Fetch-only reads on consecutive cycles
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge i_clk);
            drive(1'b1, 8'(k * 4), 1'b0, 1'b0, 8'h00, 32'h0);
            #1;
            $display("txn fetch read addr=%02h", 8'(k * 4));
            chk("fetch_if_gnt",   32'(o_if_gnt),   32'd1);
            chk("fetch_d_gnt",    32'(o_d_gnt),    32'd0);
            chk("fetch_mem_read", 32'(o_mem_read), 32'd1);
            chk("fetch_mem_addr", 32'(o_mem_addr), 32'(k * 4));
            @(posedge i_clk);
            #1;
            chk("fetch_if_rvalid", 32'(o_if_rvalid), 32'd1);
            chk("fetch_if_rdata",  o_if_rdata,       exp_fetch[k]);
            chk("fetch_d_rvalid",  32'(o_d_rvalid),  32'd0);
        end

        // Data write while fetch is also requesting
        @(negedge i_clk);
        drive(1'b1, 8'h0C, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
        #1;
        $display("txn data write addr=10 data=deadbeef with fetch pending");
        chk("wr_d_gnt",     32'(o_d_gnt),     32'd1);
        chk("wr_if_gnt",    32'(o_if_gnt),    32'd0);
        chk("wr_mem_write", 32'(o_mem_write), 32'd1);
        chk("wr_mem_read",  32'(o_mem_read),  32'd0);
        chk("wr_mem_addr",  32'(o_mem_addr),  32'h10);
        chk("wr_mem_wdata", o_mem_wdata,      32'hDEAD_BEEF);
        @(posedge i_clk);
        #1;
        chk("wr_no_if_rvalid", 32'(o_if_rvalid), 32'd0);
        chk("wr_no_d_rvalid",  32'(o_d_rvalid),  32'd0);

        @(negedge i_clk);
        drive(1'b1, 8'h0C, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        $display("txn fetch read addr=0c after write");
        chk("fw_if_gnt",    32'(o_if_gnt),   32'd1);
        chk("fw_mem_addr",  32'(o_mem_addr), 32'h0C);
        chk("fw_mem_wdata", o_mem_wdata,     32'd0);
        @(posedge i_clk);
        #1;
        chk("fw_if_rdata", o_if_rdata, 32'hA000_000C);

        @(negedge i_clk);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 32'h0);
        #1;
        $display("txn data read addr=10");
        chk("dr_d_gnt",    32'(o_d_gnt),    32'd1);
        chk("dr_mem_read", 32'(o_mem_read), 32'd1);
        @(posedge i_clk);
        #1;
        chk("dr_d_rvalid",  32'(o_d_rvalid),  32'd1);
        chk("dr_d_rdata",   o_d_rdata,        32'hDEAD_BEEF);
        chk("dr_if_rvalid", 32'(o_if_rvalid), 32'd0);
        chk("dr_if_rdata",  o_if_rdata,       32'd0);

        // Alternating data read then fetch read back-to-back
        @(negedge i_clk);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 32'h0);
        @(posedge i_clk);
        #1;
        $display("txn alt data read addr=30");
        chk("alt_d_rvalid", 32'(o_d_rvalid), 32'd1);
        chk("alt_d_rdata",  o_d_rdata,       32'hA000_0030);
        chk("alt_if_rdata", o_if_rdata,      32'd0);
        @(negedge i_clk);
        drive(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 32'h0);
        @(posedge i_clk);
        #1;
        $display("txn alt fetch read addr=20");
        chk("alt_if_rvalid", 32'(o_if_rvalid), 32'd1);
        chk("alt_if_rdata",  o_if_rdata,       32'hA000_0020);
        chk("alt_d_rvalid2", 32'(o_d_rvalid),  32'd0);
        chk("alt_d_rdata2",  o_d_rdata,        32'd0);

        @(negedge i_clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        $display("txn idle");
        chk("idle_if_gnt",   32'(o_if_gnt),   32'd0);
        chk("idle_d_gnt",    32'(o_d_gnt),    32'd0);
        chk("idle_mem_read", 32'(o_mem_read), 32'd0);
        chk("idle_mem_addr", 32'(o_mem_addr), 32'd0);

        // Reset asserted the cycle after a read grant
        @(negedge i_clk);
        drive(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0);
        @(posedge i_clk);
        #1;
        $display("txn fetch read addr=04 then reset");
        chk("rr_if_rvalid", 32'(o_if_rvalid), 32'd1);
        chk("rr_if_rdata",  o_if_rdata,       32'hA000_0004);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        chk("rr_gnt_in_reset",  32'(o_if_gnt),   32'd1);
        chk("rr_read_in_reset", 32'(o_mem_read), 32'd0);
        @(posedge i_clk);
        #1;
        chk("rr_if_rvalid_after", 32'(o_if_rvalid), 32'd0);
        chk("rr_d_rvalid_after",  32'(o_d_rvalid),  32'd0);

        // Both requesters held continuously: data x4 then fetch, period 5
        @(negedge i_clk);
        i_reset = 1'b0;
        drive(1'b1, 8'h20, 1'b1, 1'b0, 8'h30, 32'h0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge i_clk);
            #1;
            exp_f = (k == 4) || (k == 9);
            $display("txn dual request cycle %0d expect %s", k, exp_f ? "fetch" : "data");
            chk("starve_if_gnt", 32'(o_if_gnt), 32'(exp_f));
            chk("starve_d_gnt",  32'(o_d_gnt),  32'(!exp_f));
            chk("starve_excl",   32'(o_if_gnt & o_d_gnt), 32'd0);
            @(posedge i_clk);
            #1;
            chk("starve_if_rvalid", 32'(o_if_rvalid), 32'(exp_f));
            chk("starve_d_rvalid",  32'(o_d_rvalid),  32'(!exp_f));
            chk("starve_rdata", exp_f ? o_if_rdata : o_d_rdata,
                exp_f ? 32'hA000_0020 : 32'hA000_0030);
        end

        @(negedge i_clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
`ifdef MEM_ARB_STATS_EN
        #1;
        $display("txn stats readout");
        chk("stats_conflict",    o_conflict_cnt,       32'd10);
        chk("stats_starve_wins", 32'(o_starve_wins),   32'd2);
`endif
        @(posedge i_clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
